// File: rtl/r_ecc_pipe.sv
// Read-side SECDED checker/corrector: syndrome stage, then correct/flag stage.
// Latency: 2 cycles from i_vld to o_vld, one beat per cycle, beats independent.
// Backpressure: none; consumer must accept every o_vld beat.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_vld/i_data/i_chk      raw SRAM read beat (data + check bits)
//   i_addr                  read address, used only for the first-error log
//   i_correct_n             0 = correct single-bit errors, 1 = pass raw data
//   i_log_clr               clear error counters and first-error log
//   o_vld/o_data/o_chk      output beat (corrected or raw)
//   o_err_det/o_err_mult    any error / uncorrectable error on this beat
//   o_sbe_cnt/o_mbe_cnt     saturating single-/multi-bit error counts
//   o_log_*                 first-error log (valid, address, syndrome, multi-bit)
module r_ecc_pipe #(
  parameter int WDTH = 34,
  parameter int CBTS = 7,
  parameter int AW   = 12,
  parameter int CNTW = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_vld,
  input  logic [WDTH-1:0] i_data,
  input  logic [CBTS-1:0] i_chk,
  input  logic [AW-1:0]   i_addr,
  input  logic            i_correct_n,
  input  logic            i_log_clr,
  output logic            o_vld,
  output logic [WDTH-1:0] o_data,
  output logic [CBTS-1:0] o_chk,
  output logic            o_err_det,
  output logic            o_err_mult,
  output logic [CNTW-1:0] o_sbe_cnt,
  output logic [CNTW-1:0] o_mbe_cnt,
  output logic            o_log_vld,
  output logic [AW-1:0]   o_log_addr,
  output logic [CBTS-1:0] o_log_synd,
  output logic            o_log_mult
);

  localparam logic [CBTS-1:0] CHK_ONE = CBTS'(1);
  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  // Data column j of the check matrix: the j-th odd-weight (>=3) code, taking all
  // weight-3 codes in ascending value first, then weight-5, and so on. Check-bit
  // columns are one-hot, so every column is distinct and odd-weight.
  function automatic logic [CBTS-1:0] col_code(input int j);
    int n;
    logic [CBTS-1:0] v;
    n = 0;
    col_code = '0;
    for (int w = 3; w <= CBTS; w += 2) begin
      for (int k = 0; k < (1 << CBTS); k++) begin
        v = k[CBTS-1:0];
        if ($countones(v) == w) begin
          if (n == j) col_code = v;
          n++;
        end
      end
    end
  endfunction

  logic [CBTS-1:0] cols [WDTH];

  for (genvar g = 0; g < WDTH; g++) begin : g_col
    localparam logic [CBTS-1:0] CODE = col_code(g);
    assign cols[g] = CODE;
  end

  // Stage 1 registers
  logic            s1_vld;
  logic [WDTH-1:0] s1_data;
  logic [CBTS-1:0] s1_chk;
  logic [AW-1:0]   s1_addr;
  logic [CBTS-1:0] s1_synd;
  logic            s1_cn;

  // Stage 2 side registers feeding the log
  logic [AW-1:0]   s2_addr;
  logic [CBTS-1:0] s2_synd;

  logic [CBTS-1:0] enc;
  logic [WDTH-1:0] dflip;
  logic [CBTS-1:0] cflip;
  logic            sbe;
  logic            mbe;

  always_comb begin
    enc = '0;
    for (int j = 0; j < WDTH; j++) begin
      if (i_data[j]) enc = enc ^ cols[j];
    end
  end

  // A syndrome equal to exactly one column is a single-bit error in that position;
  // any other nonzero syndrome is uncorrectable.
  always_comb begin
    dflip = '0;
    cflip = '0;
    for (int j = 0; j < WDTH; j++) dflip[j] = (s1_synd == cols[j]);
    for (int k = 0; k < CBTS; k++) cflip[k] = (s1_synd == (CHK_ONE << k));
    sbe = (|dflip) | (|cflip);
    mbe = (s1_synd != '0) & ~sbe;
  end

  // Counter/log events are taken from the beat currently presented at the outputs.
  logic sbe_ev;
  logic mbe_ev;
  logic err_ev;
  assign err_ev = o_vld & o_err_det;
  assign sbe_ev = err_ev & ~o_err_mult;
  assign mbe_ev = err_ev & o_err_mult;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_vld     <= 1'b0;
      s1_data    <= '0;
      s1_chk     <= '0;
      s1_addr    <= '0;
      s1_synd    <= '0;
      s1_cn      <= 1'b0;
      s2_addr    <= '0;
      s2_synd    <= '0;
      o_vld      <= 1'b0;
      o_data     <= '0;
      o_chk      <= '0;
      o_err_det  <= 1'b0;
      o_err_mult <= 1'b0;
      o_sbe_cnt  <= '0;
      o_mbe_cnt  <= '0;
      o_log_vld  <= 1'b0;
      o_log_addr <= '0;
      o_log_synd <= '0;
      o_log_mult <= 1'b0;
    end else begin
      s1_vld <= i_vld;
      if (i_vld) begin
        s1_data <= i_data;
        s1_chk  <= i_chk;
        s1_addr <= i_addr;
        s1_synd <= enc ^ i_chk;
        s1_cn   <= i_correct_n;
      end

      o_vld <= s1_vld;
      if (s1_vld) begin
        o_data     <= s1_cn ? s1_data : (s1_data ^ dflip);
        o_chk      <= s1_cn ? s1_chk  : (s1_chk ^ cflip);
        o_err_det  <= sbe | mbe;
        o_err_mult <= mbe;
        s2_addr    <= s1_addr;
        s2_synd    <= s1_synd;
      end

      // Clear wipes old state but the beat presented this cycle still counts.
      if (i_log_clr)                          o_sbe_cnt <= sbe_ev ? CNT_ONE : '0;
      else if (sbe_ev && o_sbe_cnt != CNT_MAX) o_sbe_cnt <= o_sbe_cnt + CNT_ONE;

      if (i_log_clr)                          o_mbe_cnt <= mbe_ev ? CNT_ONE : '0;
      else if (mbe_ev && o_mbe_cnt != CNT_MAX) o_mbe_cnt <= o_mbe_cnt + CNT_ONE;

      if (i_log_clr || !o_log_vld) begin
        o_log_vld  <= err_ev;
        o_log_addr <= err_ev ? s2_addr : '0;
        o_log_synd <= err_ev ? s2_synd : '0;
        o_log_mult <= err_ev & o_err_mult;
      end
    end
  end

endmodule

// File: tb/tb_r_ecc_pipe.sv
module tb_r_ecc_pipe;

  localparam int WDTH = 34;
  localparam int CBTS = 7;
  localparam int AW   = 12;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            vld;
  logic [WDTH-1:0] data;
  logic [CBTS-1:0] chk;
  logic [AW-1:0]   addr;
  logic            correct_n;
  logic            log_clr;
  logic            o_vld;
  logic [WDTH-1:0] o_data;
  logic [CBTS-1:0] o_chk;
  logic            o_err_det;
  logic            o_err_mult;
  logic [CNTW-1:0] o_sbe_cnt;
  logic [CNTW-1:0] o_mbe_cnt;
  logic            o_log_vld;
  logic [AW-1:0]   o_log_addr;
  logic [CBTS-1:0] o_log_synd;
  logic            o_log_mult;

  r_ecc_pipe #(.WDTH(WDTH), .CBTS(CBTS), .AW(AW), .CNTW(CNTW)) dut (
    .i_clk(clk), .i_rst(rst), .i_vld(vld), .i_data(data), .i_chk(chk),
    .i_addr(addr), .i_correct_n(correct_n), .i_log_clr(log_clr),
    .o_vld(o_vld), .o_data(o_data), .o_chk(o_chk), .o_err_det(o_err_det),
    .o_err_mult(o_err_mult), .o_sbe_cnt(o_sbe_cnt), .o_mbe_cnt(o_mbe_cnt),
    .o_log_vld(o_log_vld), .o_log_addr(o_log_addr), .o_log_synd(o_log_synd),
    .o_log_mult(o_log_mult)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WDTH-1:0] d;
    logic [CBTS-1:0] c;
    logic            det;
    logic            mult;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int run = 0;
  int max_run = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Weight-3 codes enumerated by bit position (top bit outermost): column j of the
  // encoder matrix for a 7-check-bit, 34-data-bit code.
  function automatic logic [CBTS-1:0] bcol(input int j);
    int n = 0;
    bcol = '0;
    for (int c = 2; c < CBTS; c++)
      for (int b = 1; b < c; b++)
        for (int a = 0; a < b; a++) begin
          if (n == j) bcol = CBTS'((1 << a) | (1 << b) | (1 << c));
          n++;
        end
  endfunction

  function automatic logic [CBTS-1:0] encode(input logic [WDTH-1:0] d);
    encode = '0;
    for (int j = 0; j < WDTH; j++) if (d[j]) encode ^= bcol(j);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    vld = 1'b0;
    log_clr = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input logic [WDTH-1:0] d, input logic [WDTH-1:0] fd,
                      input logic [CBTS-1:0] fc, input logic [AW-1:0] a, input logic cn);
    exp_t e;
    int nb;
    nb = $countones(fd) + $countones(fc);
    vld = 1'b1;
    data = d ^ fd;
    chk = encode(d) ^ fc;
    addr = a;
    correct_n = cn;
    e.det = (nb != 0);
    e.mult = (nb >= 2);
    if (nb == 1 && !cn) begin
      e.d = d;
      e.c = encode(d);
    end else begin
      e.d = d ^ fd;
      e.c = encode(d) ^ fc;
    end
    sb.push_back(e);
    step();
  endtask

  // Output monitor: every presented beat must match the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (o_vld) begin
      run++;
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected_beat: observed o_vld=1 with data %h, expected no beat", o_data);
      end else begin
        e = sb.pop_front();
        check("o_data", 64'(o_data), 64'(e.d));
        check("o_chk", 64'(o_chk), 64'(e.c));
        check("o_err_det", 64'(o_err_det), 64'(e.det));
        check("o_err_mult", 64'(o_err_mult), 64'(e.mult));
      end
    end else begin
      run = 0;
    end
    if (run > max_run) max_run = run;
  end

  initial begin
    logic [63:0] r;
    logic [WDTH-1:0] d, fd;
    logic [CBTS-1:0] fc;
    int b;

    rst = 1'b1; vld = 1'b0; data = '0; chk = '0; addr = '0;
    correct_n = 1'b0; log_clr = 1'b0;
    repeat (3) step();
    check("rst_o_vld", 64'(o_vld), 64'd0);
    check("rst_o_data", 64'(o_data), 64'd0);
    check("rst_err_det", 64'(o_err_det), 64'd0);
    check("rst_sbe_cnt", 64'(o_sbe_cnt), 64'd0);
    check("rst_mbe_cnt", 64'(o_mbe_cnt), 64'd0);
    check("rst_log_vld", 64'(o_log_vld), 64'd0);
    rst = 1'b0;
    step();

    // 1: clean word, latency 2
    send(34'h2_DEAD_BEEF, '0, '0, 12'h001, 1'b0);
    vld = 1'b0;
    check("lat_cycle1_o_vld", 64'(o_vld), 64'd0);
    step();
    check("lat_cycle2_o_vld", 64'(o_vld), 64'd1);
    idle(3);
    check("clean_sbe_cnt", 64'(o_sbe_cnt), 64'd0);
    check("clean_log_vld", 64'(o_log_vld), 64'd0);

    // 2: single data-bit error, bit 17
    send(34'h2_DEAD_BEEF, 34'(1) << 17, '0, 12'h0A5, 1'b0);
    idle(3);
    check("sbe_sbe_cnt", 64'(o_sbe_cnt), 64'd1);
    check("sbe_log_vld", 64'(o_log_vld), 64'd1);
    check("sbe_log_addr", 64'(o_log_addr), 64'h0A5);
    check("sbe_log_mult", 64'(o_log_mult), 64'd0);
    check("sbe_log_synd", 64'(o_log_synd), 64'(bcol(17)));

    // 3: double data-bit error, bits 3 and 30; earlier SBE log entry stays
    send(34'h2_DEAD_BEEF, (34'(1) << 3) | (34'(1) << 30), '0, 12'h033, 1'b0);
    idle(3);
    check("mbe_mbe_cnt", 64'(o_mbe_cnt), 64'd1);
    check("mbe_log_addr", 64'(o_log_addr), 64'h0A5);
    check("mbe_log_mult", 64'(o_log_mult), 64'd0);

    // check-bit-only single error: data untouched, o_chk repaired
    send(34'h1_2345_6789, '0, 7'h04, 12'h044, 1'b0);
    idle(3);
    check("chkerr_sbe_cnt", 64'(o_sbe_cnt), 64'd2);

    // 4: streaming 100 back-to-back beats, every 10th with one random flip
    log_clr = 1'b1;
    step();
    idle(2);
    check("clr_sbe_cnt", 64'(o_sbe_cnt), 64'd0);
    check("clr_mbe_cnt", 64'(o_mbe_cnt), 64'd0);
    check("clr_log_vld", 64'(o_log_vld), 64'd0);
    max_run = 0;
    for (int i = 0; i < 100; i++) begin
      r = {$urandom, $urandom};
      d = r[WDTH-1:0];
      fd = '0;
      fc = '0;
      if (i % 10 == 9) begin
        b = $urandom_range(0, WDTH + CBTS - 1);
        if (b < WDTH) fd[b] = 1'b1;
        else fc[b - WDTH] = 1'b1;
      end
      send(d, fd, fc, AW'(i), 1'b0);
    end
    idle(4);
    check("stream_sbe_cnt", 64'(o_sbe_cnt), 64'd10);
    check("stream_mbe_cnt", 64'(o_mbe_cnt), 64'd0);
    check("stream_no_bubbles", 64'(max_run), 64'd100);

    // 5: saturation, then clear coinciding with an error beat at the output
    log_clr = 1'b1;
    step();
    idle(1);
    for (int i = 0; i < 20; i++) begin
      r = {$urandom, $urandom};
      send(r[WDTH-1:0], 34'(1) << (i % WDTH), '0, AW'(12'h100 + i), 1'b0);
    end
    idle(4);
    check("sat_sbe_cnt", 64'(o_sbe_cnt), 64'd15);
    check("sat_log_addr", 64'(o_log_addr), 64'h100);
    send(34'h0_0F0F_0F0F, 34'(1) << 5, '0, 12'h7E7, 1'b0);
    idle(1);
    log_clr = 1'b1;   // beat is presented at the outputs this cycle
    step();
    log_clr = 1'b0;
    step();
    check("clrhit_sbe_cnt", 64'(o_sbe_cnt), 64'd1);
    check("clrhit_log_vld", 64'(o_log_vld), 64'd1);
    check("clrhit_log_addr", 64'(o_log_addr), 64'h7E7);
    check("clrhit_log_synd", 64'(o_log_synd), 64'(bcol(5)));

    // 6: reset with beats in flight (no expectations queued: they must vanish)
    idle(2);
    vld = 1'b1; data = 34'h3_1111_2222; chk = encode(34'h3_1111_2222); addr = 12'h0AA;
    step();
    vld = 1'b1; data = 34'h0_3333_4444; chk = 7'h00; addr = 12'h0BB;
    rst = 1'b1;
    step();
    rst = 1'b0;
    vld = 1'b0;
    check("rstmid_o_vld_1", 64'(o_vld), 64'd0);
    check("rstmid_sbe_cnt", 64'(o_sbe_cnt), 64'd0);
    check("rstmid_log_vld", 64'(o_log_vld), 64'd0);
    check("rstmid_log_addr", 64'(o_log_addr), 64'd0);
    step();
    check("rstmid_o_vld_2", 64'(o_vld), 64'd0);
    send(34'h2_DEAD_BEEF, 34'(1) << 0, '0, 12'h0CC, 1'b1);
    idle(4);
    check("raw_sbe_cnt", 64'(o_sbe_cnt), 64'd1);
    check("raw_log_addr", 64'(o_log_addr), 64'h0CC);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
